// File: rtl/f8_system.sv
// f8_system: fixed-program microsequencer driving three 8-bit GPIO ports, sticky trap on read-back mismatch.
// Define GPIO_INPUT_SYNC_EN to put a two-flop synchronizer in front of the CHK comparison.
module f8_system (
  input  logic       clk,
  input  logic       power_on_reset_n,
  inout  wire  [7:0] gpio0pins,
  inout  wire  [7:0] gpio1pins,
  inout  wire  [7:0] gpio2pins,
  output logic       trap
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LDDIR = 4'h1;
  localparam logic [3:0] OP_LDOUT = 4'h2;
  localparam logic [3:0] OP_INC   = 4'h3;
  localparam logic [3:0] OP_CHK   = 4'h4;
  localparam logic [3:0] OP_JMP   = 4'h5;
  localparam logic [3:0] OP_HALT  = 4'h6;

  function automatic logic [15:0] rom_word(input logic [3:0] addr);
    case (addr)
      4'd0:    rom_word = 16'h10FF;
      4'd1:    rom_word = 16'h11FF;
      4'd2:    rom_word = 16'h12FF;
      4'd3:    rom_word = 16'h2000;
      4'd4:    rom_word = 16'h21A5;
      4'd5:    rom_word = 16'h223C;
      4'd6:    rom_word = 16'h0000;
      4'd7:    rom_word = 16'h41A5;
      4'd8:    rom_word = 16'h423C;
      4'd9:    rom_word = 16'h3000;
      4'd10:   rom_word = 16'h41A5;
      4'd11:   rom_word = 16'h5009;
      default: rom_word = 16'hF000;
    endcase
  endfunction

  logic [3:0] pc_q, pc_d;
  logic [7:0] dir_q [3];
  logic [7:0] dir_d [3];
  logic [7:0] out_q [3];
  logic [7:0] out_d [3];
  logic       trap_q, trap_d;

  logic [15:0] instr;
  logic [3:0]  op;
  logic [1:0]  port;
  logic [7:0]  imm;
  logic        unused_rsvd;

  assign instr       = rom_word(pc_q);
  assign op          = instr[15:12];
  assign port        = instr[9:8];
  assign imm         = instr[7:0];
  assign unused_rsvd = ^instr[11:10];

  for (genvar i = 0; i < 8; i++) begin : g_pin_drv
    assign gpio0pins[i] = dir_q[0][i] ? out_q[0][i] : 1'bz;
    assign gpio1pins[i] = dir_q[1][i] ? out_q[1][i] : 1'bz;
    assign gpio2pins[i] = dir_q[2][i] ? out_q[2][i] : 1'bz;
  end

  logic [7:0] pins_in [3];
  logic [7:0] chk_in  [3];

  assign pins_in[0] = gpio0pins;
  assign pins_in[1] = gpio1pins;
  assign pins_in[2] = gpio2pins;

`ifdef GPIO_INPUT_SYNC_EN
  logic [7:0] sync1_q [3];
  logic [7:0] sync1_d [3];
  logic [7:0] sync2_q [3];
  logic [7:0] sync2_d [3];

  // Synchronizers freeze with the rest of the state once trapped.
  always_comb begin
    sync1_d = sync1_q;
    sync2_d = sync2_q;
    if (!trap_q) begin
      sync1_d = pins_in;
      sync2_d = sync1_q;
    end
  end

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      sync1_q <= '{default: 8'h00};
      sync2_q <= '{default: 8'h00};
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign chk_in = sync2_q;
`else
  assign chk_in = pins_in;
`endif

  always_comb begin
    pc_d   = pc_q;
    dir_d  = dir_q;
    out_d  = out_q;
    trap_d = trap_q;
    if (!trap_q) begin
      pc_d = pc_q + 4'd1;
      // Port 3 does not exist; any port-addressed op naming it traps.
      if ((port == 2'd3) && (op >= OP_LDDIR) && (op <= OP_CHK)) begin
        trap_d = 1'b1;
        pc_d   = pc_q;
      end else begin
        case (op)
          OP_NOP:   ;
          OP_LDDIR: dir_d[port] = imm;
          OP_LDOUT: out_d[port] = imm;
          OP_INC:   out_d[port] = out_q[port] + 8'd1;
          OP_CHK:   if (chk_in[port] !== imm) trap_d = 1'b1;
          OP_JMP:   pc_d = imm[3:0];
          OP_HALT:  pc_d = pc_q;
          default: begin
            trap_d = 1'b1;
            pc_d   = pc_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge power_on_reset_n) begin
    if (!power_on_reset_n) begin
      pc_q   <= 4'd0;
      dir_q  <= '{default: 8'h00};
      out_q  <= '{default: 8'h00};
      trap_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      dir_q  <= dir_d;
      out_q  <= out_d;
      trap_q <= trap_d;
    end
  end

  assign trap = trap_q;

endmodule

// File: tb/tb_f8_system.sv
// Bench for f8_system: edge-indexed reference model of the pin waveforms plus pin-disturbance trap checks.
// Weak pulls make released pins read back deterministically: port 0 pulls low, ports 1 and 2 pull high.
module tb_f8_system;

  logic       clk = 1'b0;
  logic       power_on_reset_n = 1'b0;
  wire  [7:0] gpio0pins;
  wire  [7:0] gpio1pins;
  wire  [7:0] gpio2pins;
  logic       trap;

  logic       drv1_en;
  logic       drv2_en;
  logic [7:0] drv_val;

  assign gpio1pins = drv1_en ? drv_val : 8'hzz;
  assign gpio2pins = drv2_en ? drv_val : 8'hzz;

  for (genvar i = 0; i < 8; i++) begin : g_pull
    pulldown (gpio0pins[i]);
    pullup   (gpio1pins[i]);
    pullup   (gpio2pins[i]);
  end

  f8_system system (
    .clk              (clk),
    .power_on_reset_n (power_on_reset_n),
    .gpio0pins        (gpio0pins),
    .gpio1pins        (gpio1pins),
    .gpio2pins        (gpio2pins),
    .trap             (trap)
  );

  always #2000 clk = ~clk;

`ifdef GPIO_INPUT_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif
  localparam int NEVER = 1 << 30;

  int n_checks = 0;
  int n_errors = 0;
  int k = -1;

  typedef struct {
    int         k;
    logic [7:0] g0;
    logic [7:0] g1;
    logic [7:0] g2;
    logic       t;
  } vec_t;

  localparam int NV = 14;
  vec_t tbl [NV];

  // Pin values after edge kk (kk = -1: nothing executed yet, pins released to the pulls).
  function automatic logic [7:0] m_g0(input int kk);
    if (kk < 9) return 8'h00;
    return 8'((kk - 9) / 3 + 1);
  endfunction

  function automatic logic [7:0] m_g1(input int kk);
    if (kk < 1) return 8'hFF;
    if (kk < 4) return 8'h00;
    return 8'hA5;
  endfunction

  function automatic logic [7:0] m_g2(input int kk);
    if (kk < 2) return 8'hFF;
    if (kk < 5) return 8'h00;
    return 8'h3C;
  endfunction

  // CHK 1 runs at edge 7 and then at 10, 13, 16, ...; CHK 2 only at edge 8.
  function automatic int m_trap_edge(input int p, input int d);
    int lo;
    lo = d + 1 + SYNC_LAT;
    if (p == 2) return (lo <= 8) ? 8 : NEVER;
    if (lo <= 7) return 7;
    for (int e = 10; e < 100000; e += 3)
      if (e >= lo) return e;
    return NEVER;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    k = k + 1;
    @(negedge clk);
  endtask

  task automatic check_model(input int te, input int dist_port);
    int kf;
    kf = (k < te) ? k : te;
    chk($sformatf("gpio0 k=%0d", k), gpio0pins, m_g0(kf));
    if (dist_port != 1) chk($sformatf("gpio1 k=%0d", k), gpio1pins, m_g1(kf));
    if (dist_port != 2) chk($sformatf("gpio2 k=%0d", k), gpio2pins, m_g2(kf));
    chk($sformatf("trap k=%0d", k), {7'b0, trap}, 8'(k >= te));
  endtask

  task automatic check_released(input string tag);
    chk({tag, " gpio0 released"}, gpio0pins, 8'h00);
    chk({tag, " gpio1 released"}, gpio1pins, 8'hFF);
    chk({tag, " gpio2 released"}, gpio2pins, 8'hFF);
    chk({tag, " trap clear"}, {7'b0, trap}, 8'h00);
  endtask

  task automatic hold_reset();
    power_on_reset_n = 1'b0;
    #20000;
    check_released("reset");
    @(negedge clk);
    power_on_reset_n = 1'b1;
    k = -1;
    check_model(NEVER, 0);
  endtask

  // Reset dropped mid-cycle, far from any clock edge: must clear without a clock.
  task automatic async_reset();
    @(negedge clk);
    drv1_en = 1'b0;
    drv2_en = 1'b0;
    #500;
    power_on_reset_n = 1'b0;
    #10;
    check_released("async");
  endtask

  initial begin
    int ti;
    drv1_en = 1'b0;
    drv2_en = 1'b0;
    drv_val = 8'h00;

    tbl[0]  = '{0,    8'h00, 8'hFF, 8'hFF, 1'b0};
    tbl[1]  = '{1,    8'h00, 8'h00, 8'hFF, 1'b0};
    tbl[2]  = '{2,    8'h00, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{3,    8'h00, 8'h00, 8'h00, 1'b0};
    tbl[4]  = '{4,    8'h00, 8'hA5, 8'h00, 1'b0};
    tbl[5]  = '{5,    8'h00, 8'hA5, 8'h3C, 1'b0};
    tbl[6]  = '{8,    8'h00, 8'hA5, 8'h3C, 1'b0};
    tbl[7]  = '{9,    8'h01, 8'hA5, 8'h3C, 1'b0};
    tbl[8]  = '{11,   8'h01, 8'hA5, 8'h3C, 1'b0};
    tbl[9]  = '{12,   8'h02, 8'hA5, 8'h3C, 1'b0};
    tbl[10] = '{15,   8'h03, 8'hA5, 8'h3C, 1'b0};
    tbl[11] = '{773,  8'hFF, 8'hA5, 8'h3C, 1'b0};
    tbl[12] = '{774,  8'h00, 8'hA5, 8'h3C, 1'b0};
    tbl[13] = '{1999, 8'h98, 8'hA5, 8'h3C, 1'b0};

    hold_reset();
    ti = 0;
    for (int s = 0; s < 2000; s++) begin
      step();
      check_model(NEVER, 0);
      if (ti < NV && tbl[ti].k == k) begin
        chk($sformatf("tbl gpio0 k=%0d", k), gpio0pins, tbl[ti].g0);
        chk($sformatf("tbl gpio1 k=%0d", k), gpio1pins, tbl[ti].g1);
        chk($sformatf("tbl gpio2 k=%0d", k), gpio2pins, tbl[ti].g2);
        chk($sformatf("tbl trap k=%0d", k), {7'b0, trap}, {7'b0, tbl[ti].t});
        ti++;
      end
    end
    chk("table entries reached", 8'(ti), 8'(NV));
    async_reset();

    // Contending drive: the complement of the driven value resolves to X on every bit.
    for (int it = 0; it < 6; it++) begin
      int p, d, te, stop;
      if (it == 0) begin
        p = 1; d = 20;
      end else if (it == 1) begin
        p = 2; d = 5;
      end else begin
        p = int'($urandom_range(1, 2));
        d = (p == 1) ? int'($urandom_range(20, 60)) : int'($urandom_range(5, 7));
      end
      hold_reset();
      while (k < d) begin
        step();
        check_model(NEVER, 0);
      end
      drv_val = (p == 1) ? 8'h5A : 8'hC3;
      drv1_en = (p == 1);
      drv2_en = (p == 2);
      te   = m_trap_edge(p, d);
      stop = (te == NEVER) ? d + 15 : te + 6;
      while (k < stop) begin
        step();
        check_model(te, p);
      end
      async_reset();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
